wb_user_bus_arbiter: RTL and testbench

//  Shares the single user-space Wishbone bus between two masters: master A (Caravel host path,

---
 rtl/wb_user_bus_arbiter_pkg.sv | 35 +++
 rtl/wb_user_bus_arbiter_timeout_counter.sv | 57 +++++
 rtl/wb_user_bus_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_wb_user_bus_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_user_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// wb_user_bus_arbiter_pkg
// Shared definitions for the user-space Wishbone arbiter.
//   arb_state_e : 2-bit arbiter state encoding
//   GRANT_*     : codes driven on grant_o
//   grant_code(): maps the registered state and owner to a grant_o code
// ---------------------------------------------------------------------------
package wb_user_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_GRANT_A      = 2'd1,
        ST_GRANT_B      = 2'd2,
        ST_TIMEOUT_HOLD = 2'd3
    } arb_state_e;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_A    = 2'b01;
    localparam logic [1:0] GRANT_B    = 2'b10;

    // While a timed-out cycle is being held, the owning master still holds
    // the bus tenure, so its grant code is reported until it drops cyc.
    function automatic logic [1:0] grant_code(input arb_state_e st, input logic owner_b);
        logic [1:0] code;
        code = GRANT_NONE;
        case (st)
            ST_GRANT_A:      code = GRANT_A;
            ST_GRANT_B:      code = GRANT_B;
            ST_TIMEOUT_HOLD: code = owner_b ? GRANT_B : GRANT_A;
            default:         code = GRANT_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/wb_user_bus_arbiter_timeout_counter.sv
// ---------------------------------------------------------------------------
// wb_timeout_counter
// Watchdog counter for stalled Wishbone strobes.
//   clk       : bus clock
//   rst_n     : synchronous reset, active low
//   enable_i  : count this cycle (strobe outstanding, no ack)
//   clear_i   : return count to zero
//   expire_o  : combinational pulse, high in the cycle the count reaches
//               TIMEOUT_CYCLES-1 while still enabled
// TIMEOUT_CYCLES = 0 removes the counter entirely; expire_o is tied low.
// ---------------------------------------------------------------------------
module wb_timeout_counter
    import wb_user_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable_i,
    input  logic clear_i,
    output logic expire_o
);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wd
            localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

            logic [CNT_W-1:0] count_q;
            logic [CNT_W-1:0] count_d;

            // Saturating count so a missed expiry can never wrap around.
            always_comb begin
                count_d = count_q;
                if (clear_i) begin
                    count_d = '0;
                end else if (enable_i && (count_q != CNT_MAX)) begin
                    count_d = count_q + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            assign expire_o = enable_i && !clear_i && (count_q == CNT_LAST);
        end else begin : g_no_wd
            assign expire_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/wb_user_bus_arbiter.sv
// ---------------------------------------------------------------------------
// wb_user_bus_arbiter
// Shares the user-space Wishbone bus between master A (host path) and
// master B (debug/UART). Round-robin on contention, grant held for the whole
// cyc tenure, watchdog force-terminates stalled cycles.
// Ports:
//   wb_clk_i, wb_rst_n_i         : clock, synchronous active-low reset
//   mA_wb_* / mB_wb_*            : master-side Wishbone (cyc/stb/we/sel/adr/data in,
//                                  ack/data out)
//   userSpace_wb_*_i (out)       : slave-side request signals
//   userSpace_wb_ack_o/data_o(in): slave response
//   grant_o                      : 00 none, 01 A, 10 B
//   timeout_o                    : one-cycle pulse on forced termination
// ---------------------------------------------------------------------------
module wb_user_bus_arbiter
    import wb_user_bus_arbiter_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hFFFF_FFFF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,

    input  logic        mA_wb_cyc_i,
    input  logic        mA_wb_stb_i,
    input  logic        mA_wb_we_i,
    input  logic [3:0]  mA_wb_sel_i,
    input  logic [31:0] mA_wb_adr_i,
    input  logic [31:0] mA_wb_data_i,
    output logic        mA_wb_ack_o,
    output logic [31:0] mA_wb_data_o,

    input  logic        mB_wb_cyc_i,
    input  logic        mB_wb_stb_i,
    input  logic        mB_wb_we_i,
    input  logic [3:0]  mB_wb_sel_i,
    input  logic [31:0] mB_wb_adr_i,
    input  logic [31:0] mB_wb_data_i,
    output logic        mB_wb_ack_o,
    output logic [31:0] mB_wb_data_o,

    output logic        userSpace_wb_cyc_i,
    output logic        userSpace_wb_stb_i,
    output logic        userSpace_wb_we_i,
    output logic [3:0]  userSpace_wb_sel_i,
    output logic [31:0] userSpace_wb_adr_i,
    output logic [31:0] userSpace_wb_data_i,
    input  logic        userSpace_wb_ack_o,
    input  logic [31:0] userSpace_wb_data_o,

    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       last_b_q;   // 1: B was granted most recently (and owns the bus while granted)
    logic       last_b_d;
    logic       timeout_q;  // high for the first TIMEOUT_HOLD cycle only
    logic       timeout_d;

    logic       in_grant;
    logic       own_cyc;
    logic       own_stb;
    logic       wd_en;
    logic       wd_expire;

    // last_b_q is updated on entry to GRANT_x, so it names the owning
    // master throughout GRANT_x and TIMEOUT_HOLD.
    always_comb begin
        in_grant = (state_q == ST_GRANT_A) || (state_q == ST_GRANT_B);
        own_cyc  = last_b_q ? mB_wb_cyc_i : mA_wb_cyc_i;
        own_stb  = last_b_q ? mB_wb_stb_i : mA_wb_stb_i;
        wd_en    = in_grant && own_cyc && own_stb && !userSpace_wb_ack_o;
    end

    // An ack in the expiry cycle drops wd_en, so the ack wins over the timeout.
    wb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_counter (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_n_i),
        .enable_i (wd_en),
        .clear_i  (!wd_en),
        .expire_o (wd_expire)
    );

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        last_b_d  = last_b_q;
        timeout_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // On contention the master that was not granted last wins.
                if (mA_wb_cyc_i && (!mB_wb_cyc_i || last_b_q)) begin
                    state_d  = ST_GRANT_A;
                    last_b_d = 1'b0;
                end else if (mB_wb_cyc_i) begin
                    state_d  = ST_GRANT_B;
                    last_b_d = 1'b1;
                end
            end
            ST_GRANT_A, ST_GRANT_B: begin
                if (!own_cyc) begin
                    state_d = ST_IDLE;
                end else if (wd_expire) begin
                    state_d   = ST_TIMEOUT_HOLD;
                    timeout_d = 1'b1;
                end
            end
            ST_TIMEOUT_HOLD: begin
                if (!own_cyc) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= ST_IDLE;
            last_b_q  <= 1'b1;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_b_q  <= last_b_d;
            timeout_q <= timeout_d;
        end
    end

    // Output mux, driven only from registered state and live bus signals.
    always_comb begin
        userSpace_wb_cyc_i  = 1'b0;
        userSpace_wb_stb_i  = 1'b0;
        userSpace_wb_we_i   = 1'b0;
        userSpace_wb_sel_i  = 4'h0;
        userSpace_wb_adr_i  = 32'h0;
        userSpace_wb_data_i = 32'h0;
        mA_wb_ack_o         = 1'b0;
        mA_wb_data_o        = 32'h0;
        mB_wb_ack_o         = 1'b0;
        mB_wb_data_o        = 32'h0;
        case (state_q)
            ST_GRANT_A: begin
                userSpace_wb_cyc_i  = mA_wb_cyc_i;
                userSpace_wb_stb_i  = mA_wb_stb_i;
                userSpace_wb_we_i   = mA_wb_we_i;
                userSpace_wb_sel_i  = mA_wb_sel_i;
                userSpace_wb_adr_i  = mA_wb_adr_i;
                userSpace_wb_data_i = mA_wb_data_i;
                mA_wb_ack_o         = userSpace_wb_ack_o;
                mA_wb_data_o        = userSpace_wb_data_o;
            end
            ST_GRANT_B: begin
                userSpace_wb_cyc_i  = mB_wb_cyc_i;
                userSpace_wb_stb_i  = mB_wb_stb_i;
                userSpace_wb_we_i   = mB_wb_we_i;
                userSpace_wb_sel_i  = mB_wb_sel_i;
                userSpace_wb_adr_i  = mB_wb_adr_i;
                userSpace_wb_data_i = mB_wb_data_i;
                mB_wb_ack_o         = userSpace_wb_ack_o;
                mB_wb_data_o        = userSpace_wb_data_o;
            end
            ST_TIMEOUT_HOLD: begin
                // Slave side stays idle; any late slave ack is dropped here.
                if (last_b_q) begin
                    mB_wb_ack_o  = timeout_q;
                    mB_wb_data_o = timeout_q ? TIMEOUT_DATA : 32'h0;
                end else begin
                    mA_wb_ack_o  = timeout_q;
                    mA_wb_data_o = timeout_q ? TIMEOUT_DATA : 32'h0;
                end
            end
            default: ;
        endcase
    end

    assign grant_o   = grant_code(state_q, last_b_q);
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_user_bus_arbiter.sv
module tb_wb_user_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_cyc, a_stb, a_we;
    logic [3:0]  a_sel;
    logic [31:0] a_adr, a_dat;
    logic        a_ack;
    logic [31:0] a_rdat;
    logic        b_cyc, b_stb, b_we;
    logic [3:0]  b_sel;
    logic [31:0] b_adr, b_dat;
    logic        b_ack;
    logic [31:0] b_rdat;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_wdat;
    logic        s_ack;
    logic [31:0] s_rdat;
    logic [1:0]  grant;
    logic        tmo;

    int n_cmp = 0;
    int n_bad = 0;

    wb_user_bus_arbiter #(
        .TIMEOUT_CYCLES (8),
        .TIMEOUT_DATA   (32'hFFFF_FFFF)
    ) dut (
        .wb_clk_i            (clk),
        .wb_rst_n_i          (rst_n),
        .mA_wb_cyc_i         (a_cyc),
        .mA_wb_stb_i         (a_stb),
        .mA_wb_we_i          (a_we),
        .mA_wb_sel_i         (a_sel),
        .mA_wb_adr_i         (a_adr),
        .mA_wb_data_i        (a_dat),
        .mA_wb_ack_o         (a_ack),
        .mA_wb_data_o        (a_rdat),
        .mB_wb_cyc_i         (b_cyc),
        .mB_wb_stb_i         (b_stb),
        .mB_wb_we_i          (b_we),
        .mB_wb_sel_i         (b_sel),
        .mB_wb_adr_i         (b_adr),
        .mB_wb_data_i        (b_dat),
        .mB_wb_ack_o         (b_ack),
        .mB_wb_data_o        (b_rdat),
        .userSpace_wb_cyc_i  (s_cyc),
        .userSpace_wb_stb_i  (s_stb),
        .userSpace_wb_we_i   (s_we),
        .userSpace_wb_sel_i  (s_sel),
        .userSpace_wb_adr_i  (s_adr),
        .userSpace_wb_data_i (s_wdat),
        .userSpace_wb_ack_o  (s_ack),
        .userSpace_wb_data_o (s_rdat),
        .grant_o             (grant),
        .timeout_o           (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic set_a(input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat);
        a_cyc = cyc; a_stb = stb; a_we = we; a_sel = 4'hF; a_adr = adr; a_dat = dat;
    endtask

    task automatic set_b(input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat);
        b_cyc = cyc; b_stb = stb; b_we = we; b_sel = 4'hF; b_adr = adr; b_dat = dat;
    endtask

    task automatic set_s(input logic ack, input logic [31:0] dat);
        s_ack = ack; s_rdat = dat;
    endtask

    // Inputs change just after the falling edge; outputs are read 1 ns later.
    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        set_s(0, 0);
        repeat (2) @(posedge clk);

        // Reset state
        nxt(); #1;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_scyc",  32'(s_cyc), 0);
        chk("rst_sstb",  32'(s_stb), 0);
        chk("rst_ackA",  32'(a_ack), 0);
        chk("rst_ackB",  32'(b_ack), 0);
        chk("rst_datA",  a_rdat, 0);
        chk("rst_tmo",   32'(tmo), 0);
        rst_n = 1'b1;

        // Contention: A first (last grant is B after reset), then B, then A
        nxt(); set_a(1, 1, 0, 32'hA000_0000, 0); set_b(1, 1, 0, 32'hB000_0000, 0); #1;
        chk("t2_idle0", 32'(grant), 0);
        nxt(); set_s(1, 32'h0000_00A1); #1;
        chk("t2_grantA", 32'(grant), 1);
        chk("t2_sadrA",  s_adr, 32'hA000_0000);
        chk("t2_ackA",   32'(a_ack), 1);
        chk("t2_datA",   a_rdat, 32'h0000_00A1);
        chk("t2_ackB0",  32'(b_ack), 0);
        chk("t2_datB0",  b_rdat, 0);
        nxt(); set_a(0, 0, 0, 0, 0); set_s(0, 0); #1;
        chk("t2_dropA_grant", 32'(grant), 1);
        chk("t2_dropA_scyc",  32'(s_cyc), 0);
        nxt(); set_a(1, 1, 0, 32'hA000_0004, 0); #1;
        chk("t2_idle1", 32'(grant), 0);
        nxt(); set_s(1, 32'h0000_00B1); #1;
        chk("t2_grantB", 32'(grant), 2);
        chk("t2_sadrB",  s_adr, 32'hB000_0000);
        chk("t2_ackB",   32'(b_ack), 1);
        chk("t2_datB",   b_rdat, 32'h0000_00B1);
        chk("t2_ackA0",  32'(a_ack), 0);
        chk("t2_datA0",  a_rdat, 0);
        nxt(); set_b(0, 0, 0, 0, 0); set_s(0, 0); #1;
        chk("t2_dropB_grant", 32'(grant), 2);
        nxt(); #1;
        chk("t2_idle2", 32'(grant), 0);
        nxt(); set_s(1, 32'h0000_00A2); #1;
        chk("t2_grantA2", 32'(grant), 1);
        chk("t2_sadrA2",  s_adr, 32'hA000_0004);
        chk("t2_datA2",   a_rdat, 32'h0000_00A2);
        chk("t2_ackB1",   32'(b_ack), 0);
        nxt(); set_a(0, 0, 0, 0, 0); set_s(0, 0);
        nxt(); #1;
        chk("t2_idle3", 32'(grant), 0);

        // A alone: write with slave ack two cycles after the bus is driven
        nxt(); set_a(1, 1, 1, 32'h3000_8010, 32'h1234_5678); #1;
        chk("t1_grant0", 32'(grant), 0);
        chk("t1_scyc0",  32'(s_cyc), 0);
        nxt(); #1;
        chk("t1_grant",  32'(grant), 1);
        chk("t1_scyc",   32'(s_cyc), 1);
        chk("t1_sadr",   s_adr, 32'h3000_8010);
        chk("t1_sdat",   s_wdat, 32'h1234_5678);
        chk("t1_swe",    32'(s_we), 1);
        chk("t1_ssel",   32'(s_sel), 32'hF);
        chk("t1_ackA_w0", 32'(a_ack), 0);
        nxt(); #1;
        chk("t1_ackA_w1", 32'(a_ack), 0);
        nxt(); set_s(1, 32'h0); #1;
        chk("t1_ackA",  32'(a_ack), 1);
        chk("t1_ackB",  32'(b_ack), 0);
        nxt(); set_a(0, 0, 0, 0, 0); set_s(0, 0); #1;
        chk("t1_scyc_drop", 32'(s_cyc), 0);
        nxt(); #1;
        chk("t1_idle", 32'(grant), 0);

        // Held tenure: A does 4 beats while B waits
        nxt(); set_a(1, 1, 0, 32'h3000_0100, 0);
        nxt(); set_b(1, 1, 0, 32'hB000_0100, 0); set_s(1, 32'h0000_0101); #1;
        chk("t3_grantA", 32'(grant), 1);
        chk("t3_datA0",  a_rdat, 32'h0000_0101);
        chk("t3_ackB0",  32'(b_ack), 0);
        for (int k = 1; k < 4; k++) begin
            nxt(); set_s(1, 32'h0000_0101 + 32'(k)); #1;
            chk("t3_beat_grant", 32'(grant), 1);
            chk("t3_beat_ackA",  32'(a_ack), 1);
            chk("t3_beat_datA",  a_rdat, 32'h0000_0101 + 32'(k));
            chk("t3_beat_ackB",  32'(b_ack), 0);
        end
        nxt(); set_a(0, 0, 0, 0, 0); set_s(0, 0); #1;
        chk("t3_dropA_grant", 32'(grant), 1);
        nxt(); #1;
        chk("t3_idle", 32'(grant), 0);
        nxt(); set_s(1, 32'h0000_00B2); #1;
        chk("t3_grantB", 32'(grant), 2);
        chk("t3_datB",   b_rdat, 32'h0000_00B2);
        nxt(); set_b(0, 0, 0, 0, 0); set_s(0, 0);
        nxt(); #1;
        chk("t3_idle2", 32'(grant), 0);

        // Ack exactly on the expiry cycle (count 7): normal ack, no timeout
        nxt(); set_a(1, 1, 0, 32'h3000_0200, 0);
        for (int k = 1; k < 8; k++) begin
            nxt(); #1;
            chk("t5_no_tmo", 32'(tmo), 0);
        end
        nxt(); set_s(1, 32'h0000_0055); #1;
        chk("t5_ackA", 32'(a_ack), 1);
        chk("t5_datA", a_rdat, 32'h0000_0055);
        chk("t5_tmo",  32'(tmo), 0);
        nxt(); set_a(0, 0, 0, 0, 0); set_s(0, 0); #1;
        chk("t5_after_ackA", 32'(a_ack), 0);
        chk("t5_after_tmo",  32'(tmo), 0);
        nxt(); #1;
        chk("t5_idle", 32'(grant), 0);

        // Timeout: slave never acks for 8 strobe cycles
        nxt(); set_a(1, 1, 0, 32'h3000_0300, 0);
        for (int k = 1; k < 9; k++) begin
            nxt(); #1;
            chk("t4_stall_scyc", 32'(s_cyc), 1);
            chk("t4_stall_ackA", 32'(a_ack), 0);
        end
        nxt(); #1;
        chk("t4_ackA",  32'(a_ack), 1);
        chk("t4_datA",  a_rdat, 32'hFFFF_FFFF);
        chk("t4_tmo",   32'(tmo), 1);
        chk("t4_scyc",  32'(s_cyc), 0);
        chk("t4_sstb",  32'(s_stb), 0);
        chk("t4_ackB",  32'(b_ack), 0);
        nxt(); set_s(1, 32'h0000_0077); #1;
        chk("t4_late_ackA", 32'(a_ack), 0);
        chk("t4_late_datA", a_rdat, 0);
        chk("t4_late_tmo",  32'(tmo), 0);
        chk("t4_late_scyc", 32'(s_cyc), 0);
        nxt(); set_a(0, 0, 0, 0, 0); set_s(0, 0);
        nxt(); #1;
        chk("t4_idle", 32'(grant), 0);

        // Reset during a stalled GRANT_B cycle
        nxt(); set_b(1, 1, 0, 32'hB000_0600, 0);
        nxt(); #1;
        chk("t6_grantB", 32'(grant), 2);
        chk("t6_scyc",   32'(s_cyc), 1);
        nxt(); rst_n = 1'b0;
        nxt(); #1;
        chk("t6_rst_grant", 32'(grant), 0);
        chk("t6_rst_scyc",  32'(s_cyc), 0);
        chk("t6_rst_sstb",  32'(s_stb), 0);
        chk("t6_rst_sadr",  s_adr, 0);
        chk("t6_rst_ackB",  32'(b_ack), 0);
        chk("t6_rst_datB",  b_rdat, 0);
        chk("t6_rst_tmo",   32'(tmo), 0);
        rst_n = 1'b1;
        set_b(0, 0, 0, 0, 0);
        nxt(); set_a(1, 1, 0, 32'hA000_0600, 0); set_b(1, 1, 0, 32'hB000_0600, 0); #1;
        chk("t6_idle", 32'(grant), 0);
        nxt(); #1;
        chk("t6_grantA", 32'(grant), 1);
        chk("t6_sadrA",  s_adr, 32'hA000_0600);
        nxt(); set_a(0, 0, 0, 0, 0); set_b(0, 0, 0, 0, 0);
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
